// File: rtl/mult_unit.sv
// mult_unit: multi-cycle signed HI/LO multiplier for the execute stage.
// Radix-2 shift-add on operand magnitudes, one multiplier bit per cycle,
// followed by a sign-fix cycle that loads hi/lo.
//
// Optional feature: define MULT_UNSIGNED_EN to also accept multu (5'b10100),
// which multiplies the raw operands with no sign handling.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       instruction valid in execute this cycle
//   alucontrol  ALU decoder code (5'b10011 = mult)
//   srca        multiplicand (rs)
//   srcb        multiplier (rt)
//   stall       combinational: freeze PC/regfile while launching or in flight
//   busy        multiply in CALC or FIX
//   done        one-cycle pulse, coincident with the hi/lo update
//   hi, lo      upper/lower product words, held until the next multiply
module mult_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] ALU_MULT = 5'b10011;
`ifdef MULT_UNSIGNED_EN
  localparam logic [4:0] ALU_MULTU = 5'b10100;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [WIDTH-1:0]       mcand;
  logic [2*WIDTH-1:0]     acc;     // {partial sum, remaining multiplier bits}
  logic [CNTW-1:0]        count;
  logic                   neg;

  logic                   is_mult;
  logic                   is_multu;
  logic                   launch;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic                   neg_in;
  logic [WIDTH:0]         sum;
  logic [2*WIDTH-1:0]     product;

  // Opcode decode, operand conditioning and datapath arithmetic
  always_comb begin
    is_mult = (alucontrol == ALU_MULT);
`ifdef MULT_UNSIGNED_EN
    is_multu = (alucontrol == ALU_MULTU);
`else
    is_multu = 1'b0;
`endif
    launch = start && (state == IDLE) && (is_mult || is_multu);

    // Unsigned WIDTH-bit negation: the most negative value maps onto itself,
    // which is its correct unsigned magnitude.
    mag_a  = srca[WIDTH-1] ? -srca : srca;
    mag_b  = srcb[WIDTH-1] ? -srcb : srcb;
    op_a   = is_multu ? srca : mag_a;
    op_b   = is_multu ? srcb : mag_b;
    neg_in = is_multu ? 1'b0 : (srca[WIDTH-1] ^ srcb[WIDTH-1]);

    // Carry out of the upper half is kept and shifted back in
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    product = neg ? -acc : acc;
  end

  // Next-state and stall
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = launch;
        if (launch) state_nxt = CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (count == CNTW'(1)) state_nxt = FIX;
      end
      FIX: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CALC) || (state_nxt == FIX);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand capture, shift-add iteration and result load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand <= '0;
      acc   <= '0;
      count <= '0;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            mcand <= op_a;
            acc   <= {{WIDTH{1'b0}}, op_b};
            neg   <= neg_in;
            count <= CNTW'(WIDTH);
          end
        end
        CALC: begin
          acc   <= {sum, acc[WIDTH-1:1]};
          count <= count - CNTW'(1);
        end
        FIX: begin
          hi <= product[2*WIDTH-1:WIDTH];
          lo <= product[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: a latency/product model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_mult_unit;

  localparam int unsigned WIDTH  = 32;
  localparam int          K_LAST = WIDTH + 1;  // last stalled cycle after launch edge
  localparam int          K_DONE = WIDTH + 2;  // done pulse cycle

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [4:0]        alucontrol;
  logic [WIDTH-1:0]  srca;
  logic [WIDTH-1:0]  srcb;
  logic              stall;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  int vectors     = 0;
  int miscompares = 0;

  // Model: k = cycles elapsed since the launch edge (0 = idle)
  int          k     = 0;
  logic [63:0] mprod = '0;
  logic [31:0] mhi   = '0;
  logic [31:0] mlo   = '0;

  mult_unit #(.WIDTH(WIDTH), .CNTW(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic code_ok(input logic [4:0] code);
`ifdef MULT_UNSIGNED_EN
    return (code == 5'b10011) || (code == 5'b10100);
`else
    return (code == 5'b10011);
`endif
  endfunction

  function automatic logic model_launch();
    return start && (k == 0) && code_ok(alucontrol);
  endfunction

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] code);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (code == 5'b10100) begin
      ua = {32'h0, a};
      ub = {32'h0, b};
      return ua * ub;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Reference model advance
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k   = 0;
      mhi = '0;
      mlo = '0;
    end else if (k == 0) begin
      if (model_launch()) begin
        k     = 1;
        mprod = model_prod(srca, srcb, alucontrol);
      end
    end else if (k == K_LAST) begin
      k   = K_DONE;
      mhi = mprod[63:32];
      mlo = mprod[31:0];
    end else if (k == K_DONE) begin
      k = 0;
    end else begin
      k = k + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("cyc_stall", 64'(stall), 64'(model_launch() || (k >= 1 && k <= K_LAST)));
    check("cyc_busy",  64'(busy),  64'(k >= 1 && k <= K_LAST));
    check("cyc_done",  64'(done),  64'(k == K_DONE));
    check("cyc_hi",    64'(hi),    64'(mhi));
    check("cyc_lo",    64'(lo),    64'(mlo));
  end

  // Issue one instruction for a single cycle, then scramble inputs and
  // count stall/done cycles over a bounded window.
  task automatic mult_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] code,
                         output int stalls, output int dones);
    srca = a; srcb = b; alucontrol = code; start = 1'b1;
    stalls = 0; dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) dones++;
      @(posedge clk); #1;
      start = 1'b0; srca = $urandom; srcb = $urandom; alucontrol = 5'b00000;
    end
  endtask

  int st;
  int dn;

  initial begin
    reset = 1'b0; start = 1'b0; alucontrol = '0; srca = '0; srcb = '0;
    #2;
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Basic signed: 7 * -3 = -21
    mult_op(32'd7, 32'hFFFF_FFFD, 5'b10011, st, dn);
    check("basic_stall_cycles", 64'(st), 64'd34);
    check("basic_done_pulses", 64'(dn), 64'd1);
    check("basic_hi", 64'(hi), 64'hFFFF_FFFF);
    check("basic_lo", 64'(lo), 64'hFFFF_FFEB);

    // Reset mid-CALC: everything back to zero, no done pulse
    srca = 32'd7; srcb = 32'd9; alucontrol = 5'b10011; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_stall", 64'(stall), 64'h0);
    check("midrst_done", 64'(done), 64'h0);
    check("midrst_hi", 64'(hi), 64'h0);
    check("midrst_lo", 64'(lo), 64'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    mult_op(32'd7, 32'd9, 5'b10011, st, dn);
    check("after_rst_stall_cycles", 64'(st), 64'd34);
    check("after_rst_hi", 64'(hi), 64'h0);
    check("after_rst_lo", 64'(lo), 64'd63);

    // Extremes
    mult_op(32'h8000_0000, 32'h8000_0000, 5'b10011, st, dn);
    check("minmin_hi", 64'(hi), 64'h4000_0000);
    check("minmin_lo", 64'(lo), 64'h0000_0000);
    mult_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'b10011, st, dn);
    check("maxmax_hi", 64'(hi), 64'h3FFF_FFFF);
    check("maxmax_lo", 64'(lo), 64'h0000_0001);

    // Non-mult code held on start: never stalls, hi/lo untouched
    srca = 32'd3; srcb = 32'd4; alucontrol = 5'b00010; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("other_code_stall", 64'(stall), 64'h0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("other_code_hi", 64'(hi), 64'h3FFF_FFFF);
    check("other_code_lo", 64'(lo), 64'h0000_0001);

    // Second start during CALC is ignored; one done pulse, first operands win
    srca = 32'd5; srcb = 32'd6; alucontrol = 5'b10011; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 srca = 32'd100; srcb = 32'd100; start = 1'b1;
    dn = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) dn++;
      @(posedge clk); #1;
      if (i == 10) start = 1'b0;
    end
    start = 1'b0;
    check("restart_done_pulses", 64'(dn), 64'd1);
    check("restart_hi", 64'(hi), 64'h0);
    check("restart_lo", 64'(lo), 64'd30);

    // multu: 0xFFFFFFFF * 2
    mult_op(32'hFFFF_FFFF, 32'd2, 5'b10100, st, dn);
`ifdef MULT_UNSIGNED_EN
    check("multu_stall_cycles", 64'(st), 64'd34);
    check("multu_hi", 64'(hi), 64'h0000_0001);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);
`else
    check("multu_stall_cycles", 64'(st), 64'd0);
    check("multu_done_pulses", 64'(dn), 64'd0);
    check("multu_hi", 64'(hi), 64'h0);
    check("multu_lo", 64'(lo), 64'd30);
`endif

    // Zero operand runs full latency, then result holds while idle
    mult_op(32'h0, 32'h1234_5678, 5'b10011, st, dn);
    check("zero_stall_cycles", 64'(st), 64'd34);
    check("zero_hi", 64'(hi), 64'h0);
    check("zero_lo", 64'(lo), 64'h0);
    mult_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10011, st, dn);
    check("negneg_lo", 64'(lo), 64'h1);
    repeat (100) @(posedge clk);
    #1;
    check("hold_hi", 64'(hi), 64'h0);
    check("hold_lo", 64'(lo), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
